calc_entry_fsm: RTL
===================

# calc_entry_fsm

Operator-entry sequencer for the switch/button calculator. It debounces the two push buttons and captures operand A, operand B and an operation from the slide switches. It computes a 6-bit signed result and drives the signed value and hex/decimal mode into the seven-segment display controller directly downstream. While an operand is being entered, the display shows the live switch value; after the second entry it shows the result.

## Interface
- DEBOUNCE_CYCLES, default 1_000_000: consecutive stable cycles required to accept a button level (10 ms at 100 MHz).
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset; deassertion is synchronous to clk upstream.
- sw  input  6  raw operand switches, read as two's-complement signed (−32..31).
- op_sel  input  2  operation select: 00 add, 01 sub, 10 and, 11 xor.
- btn_enter  input  1  raw, bouncy, asynchronous enter button (active-high).
- btn_mode  input  1  raw, bouncy, asynchronous mode button (active-high).
- data  output  6  signed value to the display controller.
- display_mode  output  1  0 decimal, 1 hex; forwarded to the display controller.
- overflow  output  1  signed overflow of the last add/sub, valid in S_SHOW.
- state  output  2  current FSM state for LEDs: 00 S_LOAD_A, 01 S_LOAD_B, 10 S_SHOW.

## Operation
- **Synchroniser:** each button passes through a 2-flop synchroniser before debounce; sw and op_sel are sampled directly.
- **Debounce, per button:**
  - A counter counts cycles in which the synchronised level differs from the accepted level.
  - The counter resets to 0 whenever the levels agree.
  - When the counter reaches DEBOUNCE_CYCLES−1 while still differing, the accepted level flips and the counter clears.
  - Counter width is $clog2(DEBOUNCE_CYCLES)+1.
- **Press pulse:** a registered one-cycle high on each 0→1 transition of the accepted level. Releases produce no pulse.
- **FSM:**
  - S_LOAD_A: data <= sw every cycle. An enter press latches reg_a <= sw and moves to S_LOAD_B.
  - S_LOAD_B: data <= sw every cycle. An enter press latches reg_b <= sw and op <= op_sel, computes the result from reg_a and the current sw, and moves to S_SHOW. On the transition, data <= result and overflow <= ovf.
  - S_SHOW: data holds the result. An enter press moves to S_LOAD_A and clears overflow.
  - State encoding 11 is unreachable; if entered, the FSM returns to S_LOAD_A on the next cycle.
- **Arithmetic:**
  - All operations are 6-bit two's complement; add and sub wrap modulo 64.
  - ovf = (operand signs equal for add, or differ for sub) AND result sign ≠ A sign.
  - ovf is 0 for and and xor.
- **Mode press:** toggles display_mode in any state and is independent of the FSM.
- **Simultaneous events:** enter and mode pulses in the same cycle are both honoured.

## Timing
- **Reset values (asynchronous):** state = S_LOAD_A, data = 0, display_mode = 0, overflow = 0, reg_a = reg_b = 0. Debounce counters are 0, accepted levels are 0 and pulse registers are 0.
- **Button latency:** a raw button held stable from cycle 0 produces a press pulse at cycle DEBOUNCE_CYCLES+3 (2 synchroniser, DEBOUNCE_CYCLES count, 1 pulse register).
- **State/output latency:** state, data and overflow update on the clock edge after the pulse cycle, so there is exactly one cycle from pulse to new outputs.
- **Switch latency:** in the LOAD states, data follows sw with one-cycle latency.
- **Glitch rejection:** a glitch shorter than DEBOUNCE_CYCLES synchronised cycles resets the counter and generates no pulse.
- **Reset mid-operation:** asserting rst_n low returns to the reset values immediately. Debounce state is lost, so a button held through reset must go through a full debounce after release of reset before it produces a pulse.
- **Held button:** holding enter generates exactly one pulse; the next pulse requires release plus re-press, each fully debounced.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
1. **Reset:** assert rst_n low mid-cycle -> immediately data = 0, display_mode = 0, overflow = 0, state = 00; sw = 6'd9 after release -> data = 9 one cycle later.
2. **Add:**
   - sw = 5, press enter (held 10 cycles) -> state = 01, one pulse only.
   - sw = 7, op_sel = 00, press enter -> state = 10, data = 12, overflow = 0.
3. **Sub with negative result:** A = 3, B = 10, op_sel = 01 -> data = 6'b111001 (−7), overflow = 0. Enter again -> state = 00, overflow = 0.
4. **Overflow:** A = 31, B = 1, op_sel = 00 -> data = 6'b100000 (−32), overflow = 1. A = −32, B = 1, op_sel = 01 -> data = 31, overflow = 1.
5. **Bounce:** btn_enter pulses high for 2 cycles three times, 1 cycle apart, then stays low -> no press and state unchanged. Held high for 8 cycles -> exactly one press, occurring DEBOUNCE_CYCLES+3 cycles after the stable rise.
6. **Mode toggle and simultaneity:** mode and enter pressed simultaneously in S_LOAD_A -> display_mode = 1 and state = 01 on the same edge. Second mode press -> display_mode = 0. rst_n asserted while in S_SHOW -> state = 00.

Source files
------------

// File: rtl/calc_entry_fsm.sv
// Operator-entry sequencer: debounces the enter/mode buttons, captures two signed
// 6-bit operands and an operation, and drives the value/mode to the display controller.
`timescale 1ns/1ps

module calc_entry_fsm #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] sw,
    input  logic [1:0] op_sel,
    input  logic       btn_enter,
    input  logic       btn_mode,
    output logic [5:0] data,
    output logic       display_mode,
    output logic       overflow,
    output logic [1:0] state
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);

    localparam int BTN_ENTER = 0;
    localparam int BTN_MODE  = 1;

    typedef enum logic [1:0] {
        S_LOAD_A  = 2'b00,
        S_LOAD_B  = 2'b01,
        S_SHOW    = 2'b10,
        S_ILLEGAL = 2'b11
    } state_t;

    // Returns {overflow, result} for a 6-bit two's-complement operation.
    function automatic logic [6:0] alu(input logic [5:0] a, input logic [5:0] b,
                                       input logic [1:0] op);
        logic [5:0] r;
        logic       v;
        case (op)
            2'b00: begin
                r = a + b;
                v = (a[5] == b[5]) && (r[5] != a[5]);
            end
            2'b01: begin
                r = a - b;
                v = (a[5] != b[5]) && (r[5] != a[5]);
            end
            2'b10: begin
                r = a & b;
                v = 1'b0;
            end
            2'b11: begin
                r = a ^ b;
                v = 1'b0;
            end
            default: begin
                r = 6'd0;
                v = 1'b0;
            end
        endcase
        return {v, r};
    endfunction

    logic [1:0]          btn_raw_s;
    logic [1:0]          sync1_r;
    logic [1:0]          sync2_r;
    logic [1:0]          level_r;
    logic [1:0]          level_d_r;
    logic [1:0]          pulse_r;
    logic [1:0][CW-1:0]  cnt_r;
    logic [1:0][CW-1:0]  cnt_next_s;
    logic [1:0]          level_next_s;
    logic [1:0]          pulse_next_s;

    assign btn_raw_s = {btn_mode, btn_enter};

    // Two-flop synchroniser for both raw buttons.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 2'b00;
            sync2_r <= 2'b00;
        end else begin
            sync1_r <= btn_raw_s;
            sync2_r <= sync1_r;
        end
    end

    // Debounce counters and rising-edge detection of the accepted level.
    always_comb begin
        level_next_s = level_r;
        cnt_next_s   = cnt_r;
        for (int i = 0; i < 2; i++) begin
            if (sync2_r[i] != level_r[i]) begin
                if (cnt_r[i] == CNT_MAX) begin
                    level_next_s[i] = ~level_r[i];
                    cnt_next_s[i]   = CNT_ZERO;
                end else begin
                    cnt_next_s[i]   = cnt_r[i] + CNT_ONE;
                end
            end else begin
                cnt_next_s[i] = CNT_ZERO;
            end
        end
        pulse_next_s = level_r & ~level_d_r;
    end

    // Debounce state registers; the delayed level makes the pulse a full register stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= '0;
            level_r   <= 2'b00;
            level_d_r <= 2'b00;
            pulse_r   <= 2'b00;
        end else begin
            cnt_r     <= cnt_next_s;
            level_r   <= level_next_s;
            level_d_r <= level_r;
            pulse_r   <= pulse_next_s;
        end
    end

    state_t     state_r;
    state_t     state_next_s;
    logic [5:0] data_r;
    logic [5:0] data_next_s;
    logic       ovf_r;
    logic       ovf_next_s;
    logic       mode_r;
    logic       mode_next_s;
    logic [5:0] reg_a_r;
    logic [5:0] reg_a_next_s;
    logic [5:0] reg_b_r;
    logic [5:0] reg_b_next_s;
    logic [1:0] op_r;
    logic [1:0] op_next_s;
    logic [6:0] entry_alu_s;
    logic [6:0] show_alu_s;
    logic       enter_s;
    logic       mode_press_s;

    assign enter_s      = pulse_r[BTN_ENTER];
    assign mode_press_s = pulse_r[BTN_MODE];
    assign entry_alu_s  = alu(reg_a_r, sw, op_sel);
    // S_SHOW keeps the result from the captured operands rather than a held copy.
    assign show_alu_s   = alu(reg_a_r, reg_b_r, op_r);

    // Next-state and next-output logic for the entry sequencer.
    always_comb begin
        state_next_s = state_r;
        data_next_s  = data_r;
        ovf_next_s   = ovf_r;
        reg_a_next_s = reg_a_r;
        reg_b_next_s = reg_b_r;
        op_next_s    = op_r;

        if (mode_press_s) begin
            mode_next_s = ~mode_r;
        end else begin
            mode_next_s = mode_r;
        end

        case (state_r)
            S_LOAD_A: begin
                data_next_s = sw;
                if (enter_s) begin
                    reg_a_next_s = sw;
                    state_next_s = S_LOAD_B;
                end else begin
                    state_next_s = S_LOAD_A;
                end
            end
            S_LOAD_B: begin
                if (enter_s) begin
                    reg_b_next_s = sw;
                    op_next_s    = op_sel;
                    data_next_s  = entry_alu_s[5:0];
                    ovf_next_s   = entry_alu_s[6];
                    state_next_s = S_SHOW;
                end else begin
                    data_next_s  = sw;
                    state_next_s = S_LOAD_B;
                end
            end
            S_SHOW: begin
                data_next_s = show_alu_s[5:0];
                if (enter_s) begin
                    ovf_next_s   = 1'b0;
                    state_next_s = S_LOAD_A;
                end else begin
                    state_next_s = S_SHOW;
                end
            end
            default: begin
                state_next_s = S_LOAD_A;
            end
        endcase
    end

    // Sequencer registers; all outputs come straight from these flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_LOAD_A;
            data_r  <= 6'd0;
            ovf_r   <= 1'b0;
            mode_r  <= 1'b0;
            reg_a_r <= 6'd0;
            reg_b_r <= 6'd0;
            op_r    <= 2'b00;
        end else begin
            state_r <= state_next_s;
            data_r  <= data_next_s;
            ovf_r   <= ovf_next_s;
            mode_r  <= mode_next_s;
            reg_a_r <= reg_a_next_s;
            reg_b_r <= reg_b_next_s;
            op_r    <= op_next_s;
        end
    end

    assign data         = data_r;
    assign display_mode = mode_r;
    assign overflow     = ovf_r;
    assign state        = state_r;

endmodule
